// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the CDC FIFO write port.
// Tags each written word with the owning requester's ID.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BURST = 8,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     wclk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic                     fifo_we_o,
  output logic [WIDTH+IDW-1:0]     fifo_wdata_o,
  input  logic                     fifo_full_i
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic [IDW-1:0]     cur_id_q;
  logic [IDW-1:0]     last_id_q;
  logic [CW-1:0]      beat_cnt_q;

  logic               pick_vld;
  logic [IDW-1:0]     pick_id;
  logic [IDW-1:0]     idx_w;
  int                 idx;

  logic               in_burst;
  logic               own_vld;
  logic               own_last;
  logic [WIDTH-1:0]   own_data;
  logic               beat;
  logic               last_beat;
  logic [NUM_REQ-1:0] ready_d;

  // Walk offsets downward so the nearest one after last_id wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    idx_w    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx   = (int'(last_id_q) + i) % NUM_REQ;
      idx_w = IDW'(idx);
      if (req_valid_i[idx_w]) begin
        pick_vld = 1'b1;
        pick_id  = idx_w;
      end
    end
  end

  always_comb begin
    own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cur_id_q == IDW'(k)) begin
        own_data = req_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_burst  = (state_q == BURST);
  assign own_vld   = req_valid_i[cur_id_q];
  assign own_last  = req_last_i[cur_id_q];
  assign beat      = in_burst & own_vld
                   & ~fifo_full_i;
  assign last_beat = beat & (own_last |
    (beat_cnt_q == CW'(MAX_BURST - 1)));

  always_comb begin
    ready_d = '0;
    if (in_burst && !fifo_full_i) begin
      ready_d[cur_id_q] = 1'b1;
    end
  end

  assign req_ready_o  = ready_d;
  assign fifo_we_o    = beat;
  assign fifo_wdata_o = {cur_id_q, own_data};
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;

  always_ff @(posedge wclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
      last_id_q  <= IDW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q    <= NUM_REQ'(1) << pick_id;
            busy_q     <= 1'b1;
            cur_id_q   <= pick_id;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (last_beat) begin
            last_id_q  <= cur_id_q;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= IDLE;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios
// plus a randomized run against a reference model.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic             wclk_i = 1'b0;
  logic             rst_ni;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic             busy;
  logic             we;
  logic [W+IDW-1:0] wdata;
  logic             full;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .MAX_BURST(MB)
  ) dut (
    .wclk_i      (wclk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .fifo_we_o   (we),
    .fifo_wdata_o(wdata),
    .fifo_full_i (full)
  );

  always #5 wclk_i = ~wclk_i;

  initial begin
    #200us;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(negedge wclk_i);
  endtask

  task automatic setd(input int k,
                      input logic [W-1:0] d);
    req_data[k*W +: W] = d;
  endtask

  task automatic clr_in();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    full      = 1'b0;
  endtask

  task automatic do_reset();
    nxt();
    rst_ni = 1'b0;
    clr_in();
    nxt();
    nxt();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clr_in();
    nxt();
    req_valid = 4'b1111;
    #1;
    checks++;
    if ({grant, busy, we, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outs got g=%b b=%b we=%b r=%b want 0",
               grant, busy, we, req_ready);
    end
    nxt();
    rst_ni = 1'b1;
    req_valid = '0;
    nxt();
    #1;
    checks++;
    if ({grant, busy} !== '0) begin
      failures++;
      $display("FAIL reset_idle got g=%b b=%b want 0",
               grant, busy);
    end
  endtask

  task automatic test_single_burst();
    logic [W+IDW-1:0] exp;
    do_reset();
    nxt();
    req_valid = 4'b0100;
    setd(2, 32'hA0);
    #1;
    checks++;
    if (grant !== 4'b0000 || we !== 1'b0) begin
      failures++;
      $display("FAIL single_pre got g=%b we=%b want 0000/0",
               grant, we);
    end
    for (int i = 0; i < 3; i++) begin
      nxt();
      setd(2, 32'hA0 + i);
      req_last[2] = (i == 2);
      #1;
      exp = {2'd2, 32'hA0 + 32'(i)};
      checks++;
      if (grant !== 4'b0100 || busy !== 1'b1 ||
          we !== 1'b1 || wdata !== exp) begin
        failures++;
        $display("FAIL single_beat%0d got g=%b b=%b we=%b d=%h want 0100/1/1/%h",
                 i, grant, busy, we, wdata, exp);
      end
    end
    nxt();
    req_valid = '0;
    req_last  = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL single_end got b=%b g=%b want 0/0000",
               busy, grant);
    end
  endtask

  task automatic test_round_robin();
    int cnt [N];
    int ord;
    logic [N-1:0] eg;
    do_reset();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int c = 0; c < 15; c++) begin
      nxt();
      req_valid = 4'b1111;
      for (int k = 0; k < N; k++) begin
        req_last[k] = cnt[k][0];
        setd(k, 32'(k * 256 + c));
      end
      #1;
      ord = (c / 3) % 4;
      eg  = (c % 3 == 0) ? 4'b0000 : (4'b0001 << ord);
      checks++;
      if (grant !== eg || we !== (c % 3 != 0)) begin
        failures++;
        $display("FAIL rr_c%0d got g=%b we=%b want %b/%0d",
                 c, grant, we, eg, (c % 3 != 0));
      end
      if (c % 3 != 0) begin
        checks++;
        if (wdata[W +: IDW] !== IDW'(ord)) begin
          failures++;
          $display("FAIL rr_id_c%0d got %0d want %0d",
                   c, wdata[W +: IDW], ord);
        end
      end
      for (int k = 0; k < N; k++)
        if (req_ready[k] && req_valid[k]) cnt[k]++;
    end
    clr_in();
  endtask

  task automatic test_max_burst();
    int b = 0;
    logic       ew;
    logic [N-1:0] eg;
    int         ei;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      nxt();
      req_valid[1] = (b < 12);
      setd(1, 32'hB00 + 32'(b));
      #1;
      ew = (c >= 1 && c <= 8) || (c >= 10 && c <= 13);
      eg = (c == 0 || c == 9) ? 4'b0000 : 4'b0010;
      ei = (c <= 8) ? c - 1 : c - 2;
      checks++;
      if (we !== ew || grant !== eg) begin
        failures++;
        $display("FAIL maxb_c%0d got we=%b g=%b want %b/%b",
                 c, we, grant, ew, eg);
      end
      if (ew) begin
        checks++;
        if (wdata !== {2'd1, 32'hB00 + 32'(ei)}) begin
          failures++;
          $display("FAIL maxb_data_c%0d got %h want %h",
                   c, wdata, {2'd1, 32'hB00 + 32'(ei)});
        end
      end
      if (req_ready[1] && req_valid[1]) b++;
    end
    clr_in();
  endtask

  task automatic test_full_stall();
    int b = 0;
    logic stall, ew;
    logic [N-1:0] er, eg;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      nxt();
      stall = (c >= 3 && c <= 7);
      full  = stall;
      req_valid[0] = 1'b1;
      setd(0, 32'hC0 + 32'(b));
      #1;
      ew = (c >= 1 && c <= 13) && !stall;
      er = ew ? 4'b0001 : 4'b0000;
      eg = (c >= 1 && c <= 13) ? 4'b0001 : 4'b0000;
      checks++;
      if (we !== ew || req_ready !== er ||
          grant !== eg) begin
        failures++;
        $display("FAIL stall_c%0d got we=%b r=%b g=%b want %b/%b/%b",
                 c, we, req_ready, grant, ew, er, eg);
      end
      if (ew) begin
        checks++;
        if (wdata[W-1:0] !== 32'hC0 + 32'(b)) begin
          failures++;
          $display("FAIL stall_data_c%0d got %h want %h",
                   c, wdata[W-1:0], 32'hC0 + 32'(b));
        end
      end
      if (req_ready[0] && req_valid[0]) b++;
    end
    clr_in();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    nxt();
    req_valid = 4'b0100;
    setd(2, 32'hD0);
    nxt();
    nxt();
    nxt();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({grant, busy, we} !== '0) begin
      failures++;
      $display("FAIL rstmid got g=%b b=%b we=%b want 0",
               grant, busy, we);
    end
    nxt();
    rst_ni    = 1'b1;
    req_valid = 4'b1001;
    #1;
    checks++;
    if (grant !== 4'b0000 || we !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_rel got g=%b we=%b want 0000/0",
               grant, we);
    end
    nxt();
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_first got g=%b want 0001",
               grant);
    end
    clr_in();
  endtask

  task automatic test_owner_drop();
    do_reset();
    nxt();
    req_valid = 4'b1000;
    setd(3, 32'hE0);
    nxt();
    #1;
    checks++;
    if (grant !== 4'b1000 || we !== 1'b1) begin
      failures++;
      $display("FAIL drop_first got g=%b we=%b want 1000/1",
               grant, we);
    end
    for (int c = 0; c < 4; c++) begin
      nxt();
      req_valid = 4'b0001;
      #1;
      checks++;
      if (grant !== 4'b1000 || we !== 1'b0 ||
          req_ready !== 4'b1000) begin
        failures++;
        $display("FAIL drop_hold%0d got g=%b we=%b r=%b want 1000/0/1000",
                 c, grant, we, req_ready);
      end
    end
    nxt();
    req_valid = 4'b1001;
    req_last  = 4'b1000;
    setd(3, 32'hE1);
    #1;
    checks++;
    if (we !== 1'b1 || wdata !== {2'd3, 32'hE1}) begin
      failures++;
      $display("FAIL drop_resume got we=%b d=%h want 1/%h",
               we, wdata, {2'd3, 32'hE1});
    end
    nxt();
    req_last = '0;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL drop_gap got g=%b want 0000", grant);
    end
    nxt();
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL drop_next got g=%b want 0001", grant);
    end
    clr_in();
  endtask

  task automatic test_random();
    int own = -1;
    int lid = N - 1;
    int cnt = 0;
    int k2;
    logic [W-1:0] hd [N];
    logic         hl [N];
    logic [N-1:0] eg, er;
    logic         eb, ew, lst;
    logic [W+IDW-1:0] ed;
    do_reset();
    for (int k = 0; k < N; k++) begin
      hd[k] = $urandom;
      hl[k] = ($urandom_range(0, 99) < 20);
    end
    for (int c = 0; c < 600; c++) begin
      nxt();
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 99) < 55);
        req_last[k]  = hl[k];
        setd(k, hd[k]);
      end
      full = ($urandom_range(0, 99) < 20);
      #1;
      eg = '0;
      er = '0;
      eb = 1'b0;
      ew = 1'b0;
      ed = '0;
      if (own >= 0) begin
        eg[own] = 1'b1;
        eb = 1'b1;
        if (!full) er[own] = 1'b1;
        ew = req_valid[own] && !full;
        ed = {IDW'(own), hd[own]};
      end
      checks++;
      if ({grant, busy, we, req_ready} !==
          {eg, eb, ew, er}) begin
        failures++;
        $display("FAIL rand_c%0d got g=%b b=%b we=%b r=%b want %b/%b/%b/%b",
                 c, grant, busy, we, req_ready, eg, eb, ew, er);
      end
      if (ew) begin
        checks++;
        if (wdata !== ed) begin
          failures++;
          $display("FAIL rand_data_c%0d got %h want %h",
                   c, wdata, ed);
        end
      end
      if (own < 0) begin
        for (int i = 1; i <= N; i++) begin
          k2 = (lid + i) % N;
          if (own < 0 && req_valid[k2]) begin
            own = k2;
            cnt = 0;
          end
        end
      end else if (ew) begin
        lst = hl[own];
        hd[own] = $urandom;
        hl[own] = ($urandom_range(0, 99) < 20);
        cnt++;
        if (lst || cnt == MB) begin
          lid = own;
          own = -1;
        end
      end
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_reset_mid_burst();
    test_owner_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the clock-domain-crossing FIFO between `NUM_REQ` requesters in the write clock domain. It grants whole bursts in round-robin order. Each burst ends on a `last` flag or after `MAX_BURST` beats. The winning requester's ID is tagged onto every word so the read side can demultiplex. It sits between the write-domain masters and the FIFO's `we`/`wdata`/`full` pins.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: payload width per requester.
- `MAX_BURST`, 8: maximum beats per grant, 1..255.
- `IDW` (localparam) = `$clog2(NUM_REQ)`: ID tag width.

Ports:
- `wclk_i` in, 1: write-domain clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `req_valid_i` in, `NUM_REQ`: per-requester data valid.
- `req_last_i` in, `NUM_REQ`: per-requester end-of-burst flag, qualified by valid.
- `req_data_i` in, `NUM_REQ*WIDTH`: packed payloads. Requester k occupies `[k*WIDTH +: WIDTH]`.
- `req_ready_o` out, `NUM_REQ`: one-hot (or zero) beat accept.
- `grant_o` out, `NUM_REQ`: registered one-hot current owner, zero when idle.
- `busy_o` out, 1: high while a burst is owned.
- `fifo_we_o` out, 1: FIFO write enable.
- `fifo_wdata_o` out, `WIDTH+IDW`: `{id, payload}` with the ID in the MSBs.
- `fifo_full_i` in, 1: FIFO full, write domain.

## Operation
- The FSM has two states: IDLE and BURST.
- **IDLE:**
  - If any `req_valid_i` bit is set, select the first set bit searching upward from `last_id+1`, modulo `NUM_REQ`.
  - Register the one-hot grant into `grant_o`, store the index in `cur_id`, clear `beat_cnt`, and go to BURST.
  - Otherwise stay in IDLE.
- **BURST:**
  - A beat transfers when `req_valid_i[cur_id]` is high and `fifo_full_i` is low.
  - Combinationally: `fifo_we_o` = beat, `req_ready_o[cur_id]` = `~fifo_full_i`, `fifo_wdata_o` = `{cur_id, req_data_i[cur_id]}`.
  - On each beat, `beat_cnt` increments.
  - The burst exits when a beat has `req_last_i[cur_id]`=1 or `beat_cnt == MAX_BURST-1`. On exit: `last_id <= cur_id`, grant clears, and the FSM returns to IDLE.
  - If the owner drops valid mid-burst, the grant is held and no write occurs. There is no timeout.
  - Requests from non-owners are ignored. Their `req_ready_o` is 0.
- **Idle outputs:** `fifo_we_o`=0 and `req_ready_o`=0 outside BURST.
- **Widths:**
  - `beat_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `last_id` and `cur_id` are `IDW` bits.
  - Round-robin index arithmetic wraps at `NUM_REQ`, not at `2^IDW`.
- **Full:** `fifo_full_i` gates both `fifo_we_o` and `req_ready_o` in the same cycle. The block never asserts a write while full.

## Timing
- **Reset values:**
  - State IDLE; `grant_o`=0, `busy_o`=0, `fifo_we_o`=0, `req_ready_o`=0, `fifo_wdata_o` = don't-care (muxed from `cur_id`=0).
  - `last_id` = `NUM_REQ-1`, so requester 0 wins first; `beat_cnt`=0.
- **Arbitration latency:** valid seen in IDLE at cycle N gives `grant_o`/`busy_o` high from cycle N+1. The first beat can transfer in cycle N+1.
- **Throughput:** one beat per cycle in BURST when valid and not full.
- **Inter-burst gap:** the final beat in cycle M is followed by IDLE in M+1 and the next grant in M+2. This is one dead cycle.
- **Registered vs combinational:** `grant_o` and `busy_o` are registered. `fifo_we_o`, `req_ready_o` and `fifo_wdata_o` are combinational from registered state, `req_valid_i`, `req_data_i` and `fifo_full_i`.
- **Simultaneous `last` and `MAX_BURST`:** a single exit; `last_id` is updated once.
- **`fifo_full_i` asserted on the would-be final beat:** no beat occurs and the burst does not end. The burst ends on the next cycle in which that beat actually transfers.
- **Reset mid-burst:** all state returns to reset values immediately (asynchronous). No write is asserted during reset.

## Test plan
- **Single burst:** `NUM_REQ`=4. Requester 2 sends 3 beats (0xA0, 0xA1, 0xA2), with `last` on the 3rd. Required: `grant_o`=4'b0100 one cycle after valid; three writes with `fifo_wdata_o` = `{2'd2, 0xA0..0xA2}`; `busy_o` low one cycle after the 3rd write.
- **Round-robin contention:** all 4 requesters hold valid continuously, each sending 2-beat bursts. Required: grant order 0, 1, 2, 3, 0; exactly one dead cycle between bursts; no interleaving of IDs within a burst.
- **MAX_BURST truncation:** `MAX_BURST`=8, requester 1 streams 12 beats with no `last`. Required: 8 writes, then a re-grant after the gap. Requester 1 wins again only if no other requester is valid, and the remaining 4 beats are written.
- **Full stall:** during a burst, `fifo_full_i`=1 for 5 cycles. Required: `fifo_we_o`=0 and `req_ready_o`=0 for those 5 cycles; data order is preserved; `beat_cnt` is unchanged during the stall.
- **Reset mid-burst:** assert `rst_ni`=0 after beat 2 of 5. Required: `grant_o`, `busy_o` and `fifo_we_o` go to 0 asynchronously. After release with requesters 0 and 3 valid, requester 0 is granted first.
- **Owner drops valid:** requester 3 owns the grant and drops valid for 4 cycles while requester 0 is valid. Required: the grant stays 4'b1000 with no writes, and the burst resumes when requester 3 reasserts valid.
